// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
//   Shared types and helpers for the packet arbiter.
//   - arb_state_t : arbiter FSM states
//   - idx_w()     : index width for n sources, never less than 1
//   - onehot2idx(): position of the set bit in a one-hot vector
//                   (vectors up to MAX_N bits wide)
// ---------------------------------------------------------------------------
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_t;

    localparam int MAX_N = 64;

    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int onehot2idx(input logic [MAX_N-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker.
//   Ports:
//     req  [N-1:0]  request vector
//     ptr  [IW-1:0] index of the highest-priority input
//     pick [N-1:0]  one-hot winner (all zero when req is empty)
// ---------------------------------------------------------------------------
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick_m;
    logic [N-1:0] pick_u;

    // Requests at or above ptr form the preferred set.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    assign masked = req & mask;

    // x & -x isolates the lowest set bit: a lowest-index priority encoder.
    assign pick_m = masked & (~masked + N'(1));
    assign pick_u = req & (~req + N'(1));

    // Nothing at or above ptr: wrap around to the lowest requester overall.
    assign pick = (|masked) ? pick_m : pick_u;

endmodule

// File: rtl/axis_packet_arbiter.sv
// ---------------------------------------------------------------------------
// axis_packet_arbiter
//   Packet-level round-robin arbiter: N AXI-Stream inputs share one output.
//   The grant is taken in IDLE and held until the granted input's tlast beat
//   is accepted downstream; IDLE always lasts at least one cycle between
//   packets.
//   Ports:
//     clk, res            clock, synchronous active-high reset
//     enable              allows new grants (a locked packet always finishes)
//     s_tdata/tvalid/tlast/tready   N input streams, stream i at [i*DW +: DW]
//     m_tdata/tvalid/tlast/tready   shared output stream
//     m_tid               index of the granted input (held through IDLE)
//     busy                high while a packet is locked
//     pkt_cnt             per-input completed-packet counters, i at [i*CW +: CW]
//   Build option:
//     ARB_STATS_EN        enables pkt_cnt counters; otherwise pkt_cnt is 0
// ---------------------------------------------------------------------------
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 enable,
    input  logic [N*DW-1:0]      s_tdata,
    input  logic [N-1:0]         s_tvalid,
    input  logic [N-1:0]         s_tlast,
    output logic [N-1:0]         s_tready,
    output logic [DW-1:0]        m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    output logic [$clog2(N)-1:0] m_tid,
    input  logic                 m_tready,
    output logic                 busy,
    output logic [N*CW-1:0]      pkt_cnt
);

    localparam int IW = idx_w(N);

    arb_state_t    state_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] tid_q;

    logic [N-1:0]  pick;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] ptr_d;
    logic          end_beat;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req  (s_tvalid),
        .ptr  (ptr_q),
        .pick (pick)
    );

    assign pick_idx = IW'(onehot2idx(MAX_N'(pick)));
    // The winner drops to lowest priority for the next round.
    assign ptr_d    = (int'(pick_idx) == N - 1) ? '0 : pick_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            tid_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (enable && (|s_tvalid)) begin
                        state_q <= ARB_LOCK;
                        grant_q <= pick;
                        ptr_q   <= ptr_d;
                        tid_q   <= pick_idx;
                    end
                end
                ARB_LOCK: begin
                    if (end_beat) begin
                        state_q <= ARB_IDLE;
                        grant_q <= '0;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // grant_q is all-zero outside LOCK, so the mux output and s_tready
    // are naturally quiet in IDLE.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                m_tdata  = s_tdata[i*DW +: DW];
                m_tvalid = s_tvalid[i];
                m_tlast  = s_tlast[i];
            end
        end
    end

    assign s_tready = grant_q & {N{m_tready}};
    assign end_beat = m_tvalid & m_tready & m_tlast;
    assign busy     = (state_q == ARB_LOCK);
    assign m_tid    = tid_q;

`ifdef ARB_STATS_EN
    logic [CW-1:0] cnt_q [N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (res) begin
                cnt_q[i] <= '0;
            end else if (grant_q[i] && end_beat) begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt
        assign pkt_cnt[g*CW +: CW] = cnt_q[g];
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_packet_arbiter
//   Directed bench for axis_packet_arbiter (N=4, DW=32, CW=16).
//   Sources present data words {A, src, pkt, beat}; expected values are
//   written out per test. Build with ARB_STATS_EN to expect live counters.
// ---------------------------------------------------------------------------
module tb_axis_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 16;

`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            res;
    logic            enable;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic [1:0]      m_tid;
    logic            m_tready;
    logic            busy;
    logic [N*CW-1:0] pkt_cnt;

    axis_packet_arbiter #(
        .N  (N),
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk      (clk),
        .res      (res),
        .enable   (enable),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_tready (m_tready),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // source model state
    int           len   [N];
    int           beat  [N];
    int           pkt   [N];
    int           n_acc [N];
    logic [N-1:0] en_src;
    logic [N-1:0] gap;

    function automatic logic [31:0] mkdata(input int i, input int p, input int b);
        return {4'hA, 4'(i), 8'(p), 16'(b)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = mkdata(i, pkt[i], beat[i]);
            s_tlast[i]          = (beat[i] == len[i] - 1);
            s_tvalid[i]         = en_src[i] & ~gap[i];
        end
    endtask

    // One clock: record handshakes seen before the edge, advance sources.
    task automatic tick();
        logic [N-1:0] acc;
        #1;
        acc = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] === 1'b1) begin
                n_acc[i]++;
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    pkt[i]++;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive_src();
        #1;
    endtask

    task automatic clear_src();
        en_src = '0;
        gap    = '0;
        for (int i = 0; i < N; i++) begin
            len[i]   = 1;
            beat[i]  = 0;
            pkt[i]   = 0;
            n_acc[i] = 0;
        end
        drive_src();
    endtask

    task automatic do_reset();
        res      = 1'b1;
        enable   = 1'b0;
        m_tready = 1'b1;
        clear_src();
        tick();
        tick();
        res = 1'b0;
    endtask

    initial begin
        // ---- 1: reset state, single requester, 3-beat packet ----
        do_reset();
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tid", m_tid, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);

        enable    = 1'b1;
        len[2]    = 3;
        en_src[2] = 1'b1;
        drive_src();
        #1;
        check("t1_idle_busy", busy, 0);
        check("t1_idle_tvalid", m_tvalid, 0);
        tick();
        check("t1_tid", m_tid, 2);
        check("t1_busy", busy, 1);
        check("t1_b0_valid", m_tvalid, 1);
        check("t1_b0_data", m_tdata, mkdata(2, 0, 0));
        check("t1_s_tready", s_tready, 4'b0100);
        check("t1_b0_last", m_tlast, 0);
        tick();
        check("t1_b1_data", m_tdata, mkdata(2, 0, 1));
        tick();
        check("t1_b2_data", m_tdata, mkdata(2, 0, 2));
        check("t1_b2_last", m_tlast, 1);
        en_src[2] = 1'b0;
        tick();
        check("t1_end_busy", busy, 0);
        check("t1_end_tvalid", m_tvalid, 0);
        check("t1_end_tready", s_tready, 0);
        check("t1_end_tid_held", m_tid, 2);

        // ---- 2: all inputs continuously requesting, 2-beat packets ----
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < N; i++) len[i] = 2;
        en_src = 4'hF;
        drive_src();
        #1;
        for (int k = 0; k < 6; k++) begin
            check("t2_gap_busy", busy, 0);
            tick();
            check("t2_busy", busy, 1);
            check("t2_tid", m_tid, k % 4);
            check("t2_b0_data", m_tdata, mkdata(k % 4, k / 4, 0));
            tick();
            check("t2_b1_data", m_tdata, mkdata(k % 4, k / 4, 1));
            check("t2_b1_last", m_tlast, 1);
            if (k == 5) en_src = '0;
            tick();
        end
        check("t2_end_busy", busy, 0);
        tick();
        check("t2_quiet_busy", busy, 0);

        // ---- 3: backpressure and source gaps mid-packet ----
        do_reset();
        enable    = 1'b1;
        len[1]    = 4;
        en_src[1] = 1'b1;
        drive_src();
        #1;
        check("t3_idle_busy", busy, 0);
        tick();
        check("t3_tid", m_tid, 1);
        check("t3_b0_data", m_tdata, mkdata(1, 0, 0));
        check("t3_b0_tready", s_tready, 4'b0010);
        en_src = 4'hF;              // other inputs start requesting mid-packet
        drive_src();
        tick();
        m_tready = 1'b0;
        #1;
        check("t3_stall_tready", s_tready, 4'b0000);
        check("t3_stall_data", m_tdata, mkdata(1, 0, 1));
        check("t3_stall_valid", m_tvalid, 1);
        check("t3_stall_tid", m_tid, 1);
        tick();
        m_tready = 1'b1;
        #1;
        check("t3_b1_tready", s_tready, 4'b0010);
        check("t3_b1_data", m_tdata, mkdata(1, 0, 1));
        tick();
        gap[1] = 1'b1;
        drive_src();
        #1;
        check("t3_gap_valid", m_tvalid, 0);
        check("t3_gap_busy", busy, 1);
        check("t3_gap_tid", m_tid, 1);
        gap[1] = 1'b0;
        tick();
        check("t3_b2_valid", m_tvalid, 1);
        check("t3_b2_data", m_tdata, mkdata(1, 0, 2));
        tick();
        check("t3_b3_data", m_tdata, mkdata(1, 0, 3));
        check("t3_b3_last", m_tlast, 1);
        check("t3_b3_tready", s_tready, 4'b0010);
        en_src = '0;
        tick();
        check("t3_end_busy", busy, 0);
        check("t3_beats_src1", n_acc[1], 4);
        check("t3_beats_others", n_acc[0] + n_acc[2] + n_acc[3], 0);

        // ---- 4: pointer wrap with single-beat packets ----
        do_reset();
        enable = 1'b1;
        en_src = 4'b0100;
        drive_src();
        #1;
        check("t4_idle0", busy, 0);
        tick();
        check("t4_g2_tid", m_tid, 2);
        check("t4_g2_last", m_tlast, 1);
        check("t4_g2_busy", busy, 1);
        en_src = 4'b1001;
        tick();
        check("t4_idle1", busy, 0);
        tick();
        check("t4_wrap_tid", m_tid, 3);
        check("t4_wrap_data", m_tdata, mkdata(3, 0, 0));
        tick();
        check("t4_idle2", busy, 0);
        tick();
        check("t4_next_tid", m_tid, 0);
        check("t4_next_data", m_tdata, mkdata(0, 0, 0));
        en_src = 4'b1000;
        tick();
        check("t4_idle3", busy, 0);
        tick();
        check("t4_solo_tid", m_tid, 3);
        check("t4_solo_data", m_tdata, mkdata(3, 1, 0));
        en_src = '0;
        tick();
        check("t4_end_busy", busy, 0);

        // ---- 5: enable gating ----
        enable = 1'b0;
        len[1] = 3;
        en_src = 4'b0010;
        drive_src();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("t5_off_busy", busy, 0);
            check("t5_off_tready", s_tready, 0);
            check("t5_off_tvalid", m_tvalid, 0);
            tick();
        end
        enable = 1'b1;
        tick();
        check("t5_tid", m_tid, 1);
        check("t5_b0_data", m_tdata, mkdata(1, 0, 0));
        enable = 1'b0;
        tick();
        check("t5_b1_busy", busy, 1);
        check("t5_b1_data", m_tdata, mkdata(1, 0, 1));
        tick();
        check("t5_b2_last", m_tlast, 1);
        tick();
        check("t5_done_busy", busy, 0);
        tick();
        check("t5_stay_idle", busy, 0);
        check("t5_stay_tvalid", m_tvalid, 0);
        check("t5_pkt_cnt", pkt_cnt, STATS ? 64'h0002_0001_0001_0001 : 64'h0);

        // ---- 6: reset mid-packet, then counters ----
        enable = 1'b1;
        len[1] = 4;
        tick();
        check("t6_busy", busy, 1);
        check("t6_b0_data", m_tdata, mkdata(1, 1, 0));
        tick();
        res = 1'b1;
        tick();
        check("t6_rst_tready", s_tready, 0);
        check("t6_rst_tvalid", m_tvalid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_tid", m_tid, 0);
        check("t6_rst_pkt_cnt", pkt_cnt, 0);
        clear_src();
        res = 1'b0;
        tick();
        len[1]    = 2;
        en_src[1] = 1'b1;
        drive_src();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_cnt_tid", m_tid, 1);
            tick();
            check("t6_cnt_last", m_tlast, 1);
            if (k == 2) en_src = '0;
            tick();
        end
        check("t6_cnt1", pkt_cnt[1*CW +: CW], STATS ? 3 : 0);
        check("t6_cnt_all", pkt_cnt, STATS ? 64'h0000_0000_0003_0000 : 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
